// File: rtl/tp2_cpu_oci_trace_monitor.sv
// Debug-capture-trace monitor: stages DCT captures into a FIFO and sequences
// the capture window through CPU test shutdown until the FIFO has drained.
module tp2_cpu_oci_trace_monitor #(
    parameter int DCT_W     = 30,
    parameter int CNT_W     = 4,
    parameter int DEPTH     = 16,
    parameter int OVERWRITE = 0
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [DCT_W-1:0]         dct_buffer,
    input  logic [CNT_W-1:0]         dct_count,
    input  logic                     dct_valid,
    input  logic                     test_ending,
    input  logic                     test_has_ended,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output logic [CNT_W+DCT_W-1:0]   rd_data,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic [15:0]              drop_count,
    output logic [2:0]               state,
    output logic                     trace_done
);

    // state   | meaning
    // IDLE    | waiting for the first capture or test shutdown
    // RUN     | capturing normally
    // ENDING  | test shutdown begun, still capturing
    // DRAIN   | test ended, captures discarded, FIFO emptying
    // DONE    | FIFO empty after test end, held until reset

    localparam int AW = $clog2(DEPTH);
    localparam int EW = CNT_W + DCT_W;
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LVL_ONE    = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE    = AW'(1);
    localparam bit            OVW        = (OVERWRITE != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_RUN    = 3'd1,
        ST_ENDING = 3'd2,
        ST_DRAIN  = 3'd3,
        ST_DONE   = 3'd4
    } state_t;

    state_t          state_q;
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     level_q;
    logic            stg_valid;
    logic [EW-1:0]   stg_data;
    logic [EW-1:0]   mem [DEPTH];

    logic            capture_hit;
    logic            accept;
    logic            discard;
    logic            full;
    logic            pop;
    logic            do_write;
    logic            full_drop;
    logic            adv_rd;
    logic [1:0]      drop_inc;
    logic [16:0]     drop_sum;

    assign capture_hit = dct_valid && (dct_count != '0);
    assign accept      = capture_hit &&
                         ((state_q == ST_IDLE) || (state_q == ST_RUN) || (state_q == ST_ENDING));
    assign discard     = capture_hit && !accept;

    assign full        = (level_q == FULL_LEVEL);
    assign rd_valid    = (level_q != '0);
    assign pop         = rd_valid && rd_ready;

    // The staged capture lands in the FIFO one edge after it was accepted.
    assign do_write    = stg_valid && (!full || pop || OVW);
    assign full_drop   = stg_valid && full && !pop;
    assign adv_rd      = pop || (full_drop && OVW);

    assign drop_inc    = {1'b0, discard} + {1'b0, full_drop};
    assign drop_sum    = {1'b0, drop_count} + {15'd0, drop_inc};

    assign rd_data     = rd_valid ? mem[rd_ptr] : '0;
    assign level       = level_q;
    assign state       = state_q;

    always_ff @(posedge clk) begin
        if (reset_n && do_write) begin
            mem[wr_ptr] <= stg_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stg_valid  <= 1'b0;
            stg_data   <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            stg_valid <= accept;
            stg_data  <= {dct_count, dct_buffer};

            if (do_write) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (adv_rd) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (do_write && !adv_rd) begin
                level_q <= level_q + LVL_ONE;
            end else if (adv_rd && !do_write) begin
                level_q <= level_q - LVL_ONE;
            end

            if (drop_inc != 2'd0) begin
                overflow   <= 1'b1;
                drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            trace_done <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (test_ending) begin
                        state_q <= ST_ENDING;
                    end else if (accept) begin
                        state_q <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (test_has_ended) begin
                        state_q <= ST_DRAIN;
                    end else if (test_ending) begin
                        state_q <= ST_ENDING;
                    end
                end
                ST_ENDING: begin
                    if (test_has_ended) begin
                        state_q <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // A capture accepted in the last ENDING cycle may still be staged.
                    if ((level_q == '0) && !stg_valid) begin
                        state_q    <= ST_DONE;
                        trace_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    state_q <= ST_DONE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    trace_done <= 1'b0;
                end
            endcase
        end
    end

endmodule
